// File: rtl/regfile_nxmb.sv
// Parametrised register file: one strobed write port, NRD combinational read ports,
// sequenced clear engine. Optional write-first forwarding via macro REGFILE_NXMB_BYPASS_EN.
//
// state  | meaning
// S_IDLE | writes accepted, clr_i sampled
// S_CLR  | sweep writes INIT_VAL to one entry per cycle, writes dropped
module regfile_nxmb #(
  parameter int AW    = 3,
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int SW    = 8,
  parameter int NRD   = 2,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DW-1:0]       wdata_i,
  input  logic [DW/SW-1:0]    wstrb_i,
  input  logic                clr_i,
  output logic                busy_o,
  output logic                wr_err_o,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*DW-1:0]   rdata_o
);

  localparam int NL = DW / SW;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLR} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_wr_err;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_addr_ok;
  logic            w_wr_acc;
  logic            w_wr_drop;
  logic [NRD*DW-1:0] w_rdata;

  assign w_addr_ok = ({1'b0, waddr_i} < DEPTH_L);
  assign w_wr_acc  = wen_i && (r_state == S_IDLE) && w_addr_ok;
  assign w_wr_drop = wen_i && !w_wr_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_wr_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VAL;
    end else begin
      r_wr_err <= w_wr_drop;
      if (w_wr_acc) begin
        for (int j = 0; j < NL; j++)
          if (wstrb_i[j]) r_mem[waddr_i][j*SW +: SW] <= wdata_i[j*SW +: SW];
      end
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_state <= S_CLR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLR: begin
          r_mem[r_cnt] <= INIT_VAL;
          if (r_cnt == LAST_L) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range read addresses return zero rather than aliasing.
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      if ({1'b0, raddr_i[k*AW +: AW]} < DEPTH_L)
        w_rdata[k*DW +: DW] = r_mem[raddr_i[k*AW +: AW]];
`ifdef REGFILE_NXMB_BYPASS_EN
      if (w_wr_acc && (raddr_i[k*AW +: AW] == waddr_i)) begin
        for (int j = 0; j < NL; j++)
          if (wstrb_i[j]) w_rdata[k*DW + j*SW +: SW] = wdata_i[j*SW +: SW];
      end
`endif
    end
  end

  assign rdata_o  = w_rdata;
  assign busy_o   = r_busy;
  assign wr_err_o = r_wr_err;

endmodule

// File: tb/tb_regfile_nxmb.sv
// Bench for regfile_nxmb: 8x8 instance for directed/table checks, 6x16 instance for drops and random.
module tb_regfile_nxmb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic        a_wen, a_clr, a_busy, a_err;
  logic [2:0]  a_waddr;
  logic [7:0]  a_wdata;
  logic [0:0]  a_wstrb;
  logic [5:0]  a_raddr;
  logic [15:0] a_rdata;

  logic        b_wen, b_clr, b_busy, b_err;
  logic [3:0]  b_waddr;
  logic [15:0] b_wdata;
  logic [1:0]  b_wstrb;
  logic [7:0]  b_raddr;
  logic [31:0] b_rdata;

  regfile_nxmb #(.AW(3), .DEPTH(8), .DW(8), .SW(8), .NRD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .wen_i(a_wen), .waddr_i(a_waddr), .wdata_i(a_wdata),
    .wstrb_i(a_wstrb), .clr_i(a_clr), .busy_o(a_busy), .wr_err_o(a_err),
    .raddr_i(a_raddr), .rdata_o(a_rdata));

  regfile_nxmb #(.AW(4), .DEPTH(6), .DW(16), .SW(8), .NRD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wen_i(b_wen), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .wstrb_i(b_wstrb), .clr_i(b_clr), .busy_o(b_busy), .wr_err_o(b_err),
    .raddr_i(b_raddr), .rdata_o(b_rdata));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic a_chk_all(input string nm, input int split, input logic [7:0] lo_v,
                           input logic [7:0] hi_v);
    for (int i = 0; i < 8; i++) begin
      a_raddr = {i[2:0], i[2:0]};
      #1;
      chk(nm, {24'd0, a_rdata[7:0]},  {24'd0, (i < split) ? lo_v : hi_v});
      chk(nm, {24'd0, a_rdata[15:8]}, {24'd0, (i < split) ? lo_v : hi_v});
    end
  endtask

  task automatic a_fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_wen = 1'b1; a_waddr = i[2:0]; a_wdata = v; a_wstrb = 1'b1;
    end
    @(negedge clk);
    a_wen = 1'b0;
  endtask

  typedef struct {
    logic       wen;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [0:0] wstrb;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vt [6];

  logic [15:0] m [6];
  logic        m_busy, m_err;
  int          m_idx;
  int          busy_cnt;
  logic [7:0]  exp8;

  initial begin
    vt[0] = '{1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 3'd3, 8'hA5, 8'hA5};
    vt[1] = '{1'b1, 3'd0, 8'h11, 1'b1, 3'd0, 3'd3, 8'h11, 8'hA5};
    vt[2] = '{1'b1, 3'd7, 8'hFF, 1'b0, 3'd7, 3'd0, 8'h00, 8'h11};
    vt[3] = '{1'b1, 3'd7, 8'hC3, 1'b1, 3'd7, 3'd7, 8'hC3, 8'hC3};
    vt[4] = '{1'b0, 3'd1, 8'h99, 1'b1, 3'd1, 3'd7, 8'h00, 8'hC3};
    vt[5] = '{1'b1, 3'd1, 8'h99, 1'b1, 3'd1, 3'd0, 8'h99, 8'h11};

    a_wen = 0; a_waddr = 0; a_wdata = 0; a_wstrb = 0; a_clr = 0; a_raddr = 0;
    b_wen = 0; b_waddr = 0; b_wdata = 0; b_wstrb = 0; b_clr = 0; b_raddr = 0;

    // Reset state
    #15;
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_err",  {31'd0, a_err},  32'd0);
    a_chk_all("rst_read", 8, 8'h00, 8'h00);
    b_raddr = {4'd9, 4'd15};
    #1;
    chk("rst_oor", b_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven writes and dual-port reads
    foreach (vt[i]) begin
      @(negedge clk);
      a_wen = vt[i].wen; a_waddr = vt[i].waddr; a_wdata = vt[i].wdata; a_wstrb = vt[i].wstrb;
      a_raddr = {vt[i].ra1, vt[i].ra0};
      @(posedge clk); #1;
      chk($sformatf("vec%0d_p0", i), {24'd0, a_rdata[7:0]},  {24'd0, vt[i].e0});
      chk($sformatf("vec%0d_p1", i), {24'd0, a_rdata[15:8]}, {24'd0, vt[i].e1});
      chk($sformatf("vec%0d_err", i), {31'd0, a_err}, 32'd0);
    end
    @(negedge clk);
    a_wen = 1'b0;

    // Clear sweep with ignored clr_i and dropped writes
    a_fill(8'h5A);
    a_chk_all("fill5a", 8, 8'h5A, 8'h5A);
    @(negedge clk);
    a_clr = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", {31'd0, a_busy}, 32'd1);
    busy_cnt = a_busy ? 1 : 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      a_clr = (c == 2 || c == 3);
      a_wen = (c == 5 || c == 6);
      a_waddr = 3'd7; a_wdata = 8'h11; a_wstrb = 1'b1;
      @(posedge clk); #1;
      if (a_busy) busy_cnt++;
      if (c == 4) a_chk_all("mid_sweep", 4, 8'h00, 8'h5A);
      if (c == 5) chk("drop1_err", {31'd0, a_err}, 32'd1);
      if (c == 6) begin
        chk("drop2_err", {31'd0, a_err}, 32'd1);
        a_raddr = {3'd7, 3'd7};
        #1;
        chk("drop_nowrite", {24'd0, a_rdata[7:0]}, 32'h5A);
      end
      if (c == 7) chk("drop_err_fall", {31'd0, a_err}, 32'd0);
      if (c == 8) chk("busy_fall", {31'd0, a_busy}, 32'd0);
    end
    chk("busy_len", busy_cnt, 32'd8);
    @(negedge clk);
    a_wen = 1'b0; a_clr = 1'b0;
    a_chk_all("after_sweep", 8, 8'h00, 8'h00);

    // Reset mid-sweep
    a_fill(8'h77);
    @(negedge clk);
    a_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_busy_pre", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, a_busy}, 32'd0);
    a_chk_all("rstmid_read", 8, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle write/read: forwarding depends on build
    @(negedge clk);
    a_wen = 1'b1; a_waddr = 3'd2; a_wdata = 8'h55; a_wstrb = 1'b1;
    @(negedge clk);
    a_wdata = 8'h3C; a_raddr = {3'd5, 3'd2};
    #1;
`ifdef REGFILE_NXMB_BYPASS_EN
    exp8 = 8'h3C;
`else
    exp8 = 8'h55;
`endif
    chk("same_cycle_p0", {24'd0, a_rdata[7:0]}, {24'd0, exp8});
    chk("same_cycle_p1", {24'd0, a_rdata[15:8]}, 32'd0);
    @(posedge clk); #1;
    chk("next_cycle", {24'd0, a_rdata[7:0]}, 32'h3C);
    @(negedge clk);
    a_wen = 1'b0;

    // Lane strobes and out-of-range drops on the 6x16 instance
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 4'd1; b_wdata = 16'h1234; b_wstrb = 2'b11;
    @(negedge clk);
    b_wdata = 16'hBEEF; b_wstrb = 2'b10;
    @(negedge clk);
    b_wen = 1'b0; b_raddr = {4'd9, 4'd1};
    #1;
    chk("lane_merge", {16'd0, b_rdata[15:0]}, 32'hBE34);
    chk("oor_read9", {16'd0, b_rdata[31:16]}, 32'd0);
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 4'd8; b_wdata = 16'hFFFF; b_wstrb = 2'b11;
    @(posedge clk); #1;
    chk("oor_err", {31'd0, b_err}, 32'd1);
    @(negedge clk);
    b_wen = 1'b0;
    @(posedge clk); #1;
    chk("oor_err_pulse", {31'd0, b_err}, 32'd0);
    chk("oor_nowrite", {16'd0, b_rdata[15:0]}, 32'hBE34);
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 4'd8;
    @(posedge clk); #1;
    chk("dbl_err1", {31'd0, b_err}, 32'd1);
    @(negedge clk);
    b_waddr = 4'd12;
    @(posedge clk); #1;
    chk("dbl_err2", {31'd0, b_err}, 32'd1);
    @(negedge clk);
    b_wen = 1'b0;
    @(posedge clk); #1;
    chk("dbl_err_fall", {31'd0, b_err}, 32'd0);

    // Randomized traffic against a reference model
    foreach (m[i]) m[i] = 16'h0000;
    m[1] = 16'hBE34;
    m_busy = 1'b0; m_err = 1'b0; m_idx = 0;
    for (int n = 0; n < 400; n++) begin
      logic acc;
      logic [15:0] e [2];
      @(negedge clk);
      b_wen   = 1'($urandom_range(0, 1));
      b_waddr = 4'($urandom_range(0, 8));
      b_wdata = 16'($urandom);
      b_wstrb = 2'($urandom);
      b_clr   = ($urandom_range(0, 15) == 0);
      b_raddr = 8'($urandom);
      if (n % 3 == 0) b_raddr[3:0] = b_waddr;
      acc = b_wen && !m_busy && (b_waddr < 6);
      for (int k = 0; k < 2; k++) begin
        logic [3:0] ra;
        ra = b_raddr[k*4 +: 4];
        e[k] = (ra < 6) ? m[ra] : 16'h0000;
`ifdef REGFILE_NXMB_BYPASS_EN
        if (acc && ra == b_waddr) begin
          if (b_wstrb[0]) e[k][7:0]  = b_wdata[7:0];
          if (b_wstrb[1]) e[k][15:8] = b_wdata[15:8];
        end
`endif
      end
      #1;
      chk($sformatf("rnd%0d_p0", n), {16'd0, b_rdata[15:0]},  {16'd0, e[0]});
      chk($sformatf("rnd%0d_p1", n), {16'd0, b_rdata[31:16]}, {16'd0, e[1]});
      @(posedge clk);
      m_err = b_wen && !acc;
      if (acc) begin
        if (b_wstrb[0]) m[b_waddr][7:0]  = b_wdata[7:0];
        if (b_wstrb[1]) m[b_waddr][15:8] = b_wdata[15:8];
      end
      if (m_busy) begin
        m[m_idx] = 16'h0000;
        if (m_idx == 5) m_busy = 1'b0;
        else m_idx++;
      end else if (b_clr) begin
        m_busy = 1'b1;
        m_idx = 0;
      end
      #1;
      chk($sformatf("rnd%0d_busy", n), {31'd0, b_busy}, {31'd0, m_busy});
      chk($sformatf("rnd%0d_err", n),  {31'd0, b_err},  {31'd0, m_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
